// File: rtl/csr_if.sv
// CSR access bus between the CSR access/ALU stage (master) and the CSR register file (slave).
interface csr_if;
    logic        csr_ren;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_ren, csr_wen, csr_addr, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_ren, csr_wen, csr_addr, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: trap CSRs, 64-bit cycle/instret counters, ID registers.
// Optional feature: define CSR_MCOUNTINHIBIT_EN to add mcountinhibit at 0x320.
module csr_file #(
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] MHARTID_VAL = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTN,
    csr_if.slave        bus,
    input  logic        instret_inc,
    input  logic        trap_vld,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_glb_o
);

    function automatic logic [31:0] align4(input logic [31:0] v);
        return v & ~32'h0000_0003;
    endfunction

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;
    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        cy_inh_s;
    logic        ir_inh_s;
    logic [31:0] mstatus_s;
    logic [31:0] rd_val_s;
    logic        mapped_s;
    logic        ro_s;
    logic        we_s;

`ifdef CSR_MCOUNTINHIBIT_EN
    logic        inh_cy_q, inh_cy_d;
    logic        inh_ir_q, inh_ir_d;
    assign cy_inh_s = inh_cy_q;
    assign ir_inh_s = inh_ir_q;
`else
    assign cy_inh_s = 1'b0;
    assign ir_inh_s = 1'b0;
`endif

    assign mstatus_s = {24'h00_0000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};

    // Address decode and read mux; the whole 0xC00-0xFFF quadrant plus misa is read-only
    always_comb begin
        rd_val_s = 32'h0000_0000;
        mapped_s = 1'b1;
        ro_s     = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == 12'h301);
        case (bus.csr_addr)
            12'h300: rd_val_s = mstatus_s;
            12'h301: rd_val_s = MISA_VAL;
            12'h304: rd_val_s = mie_q;
            12'h305: rd_val_s = mtvec_q;
            12'h340: rd_val_s = mscratch_q;
            12'h341: rd_val_s = mepc_q;
            12'h342: rd_val_s = mcause_q;
            12'h343: rd_val_s = mtval_q;
            12'hB00, 12'hC00: rd_val_s = mcycle_q[31:0];
            12'hB80, 12'hC80: rd_val_s = mcycle_q[63:32];
            12'hB02, 12'hC02: rd_val_s = minstret_q[31:0];
            12'hB82, 12'hC82: rd_val_s = minstret_q[63:32];
            12'hF11, 12'hF12, 12'hF13: rd_val_s = 32'h0000_0000;
            12'hF14: rd_val_s = MHARTID_VAL;
`ifdef CSR_MCOUNTINHIBIT_EN
            12'h320: rd_val_s = {29'h0000_0000, inh_ir_q, 1'b0, inh_cy_q};
`endif
            default: begin
                rd_val_s = 32'h0000_0000;
                mapped_s = 1'b0;
            end
        endcase
    end

    assign bus.csr_rdata   = bus.csr_ren ? rd_val_s : 32'h0000_0000;
    assign bus.csr_illegal = ((bus.csr_ren | bus.csr_wen) & ~mapped_s) | (bus.csr_wen & ro_s);
    assign we_s            = bus.csr_wen & mapped_s & ~ro_s;

    // Trap/MRET/software-write arbitration for the trap-related CSRs (trap > mret > write)
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mscratch_d     = mscratch_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_vld) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (we_s && (bus.csr_addr == 12'h300)) begin
            mstatus_mie_d  = bus.csr_wdata[3];
            mstatus_mpie_d = bus.csr_wdata[7];
        end else begin
            mstatus_mie_d  = mstatus_mie_q;
            mstatus_mpie_d = mstatus_mpie_q;
        end
        if (trap_vld) begin
            mepc_d   = align4(trap_pc);
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
        end else if (we_s) begin
            case (bus.csr_addr)
                12'h341: mepc_d   = align4(bus.csr_wdata);
                12'h342: mcause_d = bus.csr_wdata;
                12'h343: mtval_d  = bus.csr_wdata;
                default: mepc_d   = mepc_q;
            endcase
        end else begin
            mepc_d = mepc_q;
        end
        if (we_s) begin
            case (bus.csr_addr)
                12'h304: mie_d      = bus.csr_wdata;
                12'h305: mtvec_d    = align4(bus.csr_wdata);
                12'h340: mscratch_d = bus.csr_wdata;
                default: mie_d      = mie_q;
            endcase
        end else begin
            mie_d = mie_q;
        end
    end

    // Counters: a software write to either half replaces that cycle's increment
    always_comb begin
        if (we_s && (bus.csr_addr == 12'hB00)) begin
            mcycle_d = {mcycle_q[63:32], bus.csr_wdata};
        end else if (we_s && (bus.csr_addr == 12'hB80)) begin
            mcycle_d = {bus.csr_wdata, mcycle_q[31:0]};
        end else if (!cy_inh_s) begin
            mcycle_d = mcycle_q + 64'd1;
        end else begin
            mcycle_d = mcycle_q;
        end
        if (we_s && (bus.csr_addr == 12'hB02)) begin
            minstret_d = {minstret_q[63:32], bus.csr_wdata};
        end else if (we_s && (bus.csr_addr == 12'hB82)) begin
            minstret_d = {bus.csr_wdata, minstret_q[31:0]};
        end else if (instret_inc && !ir_inh_s) begin
            minstret_d = minstret_q + 64'd1;
        end else begin
            minstret_d = minstret_q;
        end
    end

`ifdef CSR_MCOUNTINHIBIT_EN
    // mcountinhibit: only CY and IR are implemented
    always_comb begin
        if (we_s && (bus.csr_addr == 12'h320)) begin
            inh_cy_d = bus.csr_wdata[0];
            inh_ir_d = bus.csr_wdata[2];
        end else begin
            inh_cy_d = inh_cy_q;
            inh_ir_d = inh_ir_q;
        end
    end

    // mcountinhibit state with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            inh_cy_q <= 1'b0;
            inh_ir_q <= 1'b0;
        end else begin
            inh_cy_q <= inh_cy_d;
            inh_ir_q <= inh_ir_d;
        end
    end
`endif

    // CSR state with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0000_0000;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= 32'h0000_0000;
            mscratch_q     <= 32'h0000_0000;
            mcause_q       <= 32'h0000_0000;
            mtval_q        <= 32'h0000_0000;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mscratch_q     <= mscratch_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign mtvec_o   = mtvec_q;
    assign mepc_o    = mepc_q;
    assign mie_glb_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; inputs change after the falling edge, outputs are sampled mid-low-phase.
module tb_csr_file;
    logic        clk = 1'b0;
    logic        rstn;
    logic        instret_inc;
    logic        trap_vld;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_glb_o;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rdv;
    logic        ilv;
    logic [7:0]  pat;

    csr_if bus ();

    csr_file dut (
        .CLK         (clk),
        .RSTN        (rstn),
        .bus         (bus),
        .instret_inc (instret_inc),
        .trap_vld    (trap_vld),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_tval   (trap_tval),
        .mret        (mret),
        .mtvec_o     (mtvec_o),
        .mepc_o      (mepc_o),
        .mie_glb_o   (mie_glb_o)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic il);
        bus.csr_addr = a;
        bus.csr_ren  = 1'b1;
        #1;
        d = bus.csr_rdata;
        il = bus.csr_illegal;
        bus.csr_ren = 1'b0;
    endtask

    task automatic chkrd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        il;
        rd(a, d, il);
        chk(tag, d, exp);
    endtask

    task automatic edge1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        bus.csr_wen   = 1'b1;
        edge1();
        bus.csr_wen   = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; instret_inc = 1'b0; trap_vld = 1'b0; mret = 1'b0;
        trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
        bus.csr_ren = 1'b0; bus.csr_wen = 1'b0; bus.csr_addr = 12'h000; bus.csr_wdata = 32'h0;
        repeat (3) @(negedge clk);

        #1;
        chk("rst_rdata_idle", bus.csr_rdata, 32'h0);
        chk("rst_illegal_idle", {31'h0, bus.csr_illegal}, 32'h0);
        chk("rst_mtvec_o", mtvec_o, 32'h0);
        chk("rst_mepc_o", mepc_o, 32'h0);
        chk("rst_mie_glb", {31'h0, mie_glb_o}, 32'h0);
        chkrd("rst_mcycle", 12'hB00, 32'h0);

        // 1: ten cycles out of reset, ID registers
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        rd(12'hB00, rdv, ilv);
        chk("mcycle_10", rdv, 32'd10);
        chk("mcycle_ill", {31'h0, ilv}, 32'h0);
        chkrd("misa", 12'h301, 32'h4000_0100);
        chkrd("mhartid", 12'hF14, 32'h0);
        chkrd("mcycleh_0", 12'hB80, 32'h0);

        // 2: lo-word write then carry into hi
        wr(12'hB00, 32'hFFFF_FFFE);
        repeat (3) @(negedge clk);
        chkrd("mcycleh_carry", 12'hB80, 32'h1);
        chkrd("mcycle_carry", 12'hB00, 32'h1);
        chkrd("cycleh_alias", 12'hC80, 32'h1);

        // 3: mtvec alignment, RO and unmapped accesses
        wr(12'h305, 32'h1234_5677);
        chkrd("mtvec_align", 12'h305, 32'h1234_5674);
        chk("mtvec_o", mtvec_o, 32'h1234_5674);
        bus.csr_addr = 12'hC00; bus.csr_wdata = 32'h0; bus.csr_wen = 1'b1;
        #1;
        chk("wr_ro_illegal", {31'h0, bus.csr_illegal}, 32'h1);
        edge1();
        bus.csr_wen = 1'b0;
        chkrd("mcycle_after_ro", 12'hB00, 32'h3);
        chkrd("mcycleh_after_ro", 12'hB80, 32'h1);
        rd(12'h7C0, rdv, ilv);
        chk("unmapped_rdata", rdv, 32'h0);
        chk("unmapped_ill", {31'h0, ilv}, 32'h1);
        wr(12'h301, 32'h0);
        chkrd("misa_unwritten", 12'h301, 32'h4000_0100);

        // 4: mstatus masking, trap, mret and priorities
        wr(12'h300, 32'hFFFF_FFFF);
        chkrd("mstatus_mask", 12'h300, 32'h88);
        wr(12'h300, 32'h8);
        chkrd("mstatus_mie", 12'h300, 32'h8);
        chk("mie_glb_set", {31'h0, mie_glb_o}, 32'h1);
        trap_vld = 1'b1; trap_pc = 32'h103; trap_cause = 32'd11; trap_tval = 32'hDEAD_BEEF;
        bus.csr_addr = 12'h341; bus.csr_wdata = 32'h200; bus.csr_wen = 1'b1;
        edge1();
        trap_vld = 1'b0; bus.csr_wen = 1'b0;
        chk("trap_mepc_o", mepc_o, 32'h100);
        chkrd("trap_mepc", 12'h341, 32'h100);
        chkrd("trap_mstatus", 12'h300, 32'h80);
        chkrd("trap_mcause", 12'h342, 32'd11);
        chkrd("trap_mtval", 12'h343, 32'hDEAD_BEEF);
        chk("trap_mie_glb", {31'h0, mie_glb_o}, 32'h0);
        mret = 1'b1;
        edge1();
        mret = 1'b0;
        chkrd("mret_mstatus", 12'h300, 32'h88);
        chk("mret_mie_glb", {31'h0, mie_glb_o}, 32'h1);
        trap_vld = 1'b1; mret = 1'b1; trap_pc = 32'h204; trap_cause = 32'd3;
        bus.csr_addr = 12'h340; bus.csr_wdata = 32'h5A5A; bus.csr_wen = 1'b1;
        edge1();
        trap_vld = 1'b0; mret = 1'b0; bus.csr_wen = 1'b0;
        chkrd("trapmret_mstatus", 12'h300, 32'h80);
        chkrd("trapmret_mepc", 12'h341, 32'h204);
        chkrd("trap_mscratch", 12'h340, 32'h5A5A);
        chkrd("trapmret_mcause", 12'h342, 32'd3);
        mret = 1'b1;
        bus.csr_addr = 12'h300; bus.csr_wdata = 32'h0; bus.csr_wen = 1'b1;
        edge1();
        mret = 1'b0; bus.csr_wen = 1'b0;
        chkrd("mret_over_wr", 12'h300, 32'h88);

        // 5: minstret counting, carry, write-wins, mid-run reset
        pat = 8'b1011_0101;
        for (int i = 7; i >= 0; i--) begin
            instret_inc = pat[i];
            edge1();
        end
        instret_inc = 1'b0;
        chkrd("minstret_5", 12'hB02, 32'd5);
        chkrd("instret_alias", 12'hC02, 32'd5);
        chkrd("minstreth_0", 12'hB82, 32'h0);
        wr(12'hB02, 32'hFFFF_FFFF);
        instret_inc = 1'b1;
        edge1();
        instret_inc = 1'b0;
        chkrd("minstreth_carry", 12'hB82, 32'h1);
        chkrd("minstret_wrap", 12'hB02, 32'h0);
        instret_inc = 1'b1;
        bus.csr_addr = 12'hB82; bus.csr_wdata = 32'h7; bus.csr_wen = 1'b1;
        edge1();
        instret_inc = 1'b0; bus.csr_wen = 1'b0;
        chkrd("minstreth_wr_wins", 12'hB82, 32'h7);
        chkrd("minstret_lo_held", 12'hB02, 32'h0);
        rstn = 1'b0;
        edge1();
        rstn = 1'b1;
        chkrd("rst2_mcycle", 12'hB00, 32'h0);
        chkrd("rst2_minstreth", 12'hB82, 32'h0);
        chkrd("rst2_mtvec", 12'h305, 32'h0);
        chkrd("rst2_mstatus", 12'h300, 32'h0);
        chkrd("rst2_mscratch", 12'h340, 32'h0);
        chk("rst2_mepc_o", mepc_o, 32'h0);

        // 6: mcountinhibit
`ifdef CSR_MCOUNTINHIBIT_EN
        wr(12'h320, 32'hFFFF_FFFF);
        chkrd("mcountinhibit_mask", 12'h320, 32'h5);
        instret_inc = 1'b1;
        repeat (20) @(negedge clk);
        instret_inc = 1'b0;
        chkrd("inh_mcycle_frozen", 12'hB00, 32'h1);
        chkrd("inh_minstret_frozen", 12'hB02, 32'h0);
        wr(12'h320, 32'h0);
        repeat (4) @(negedge clk);
        chkrd("inh_mcycle_resume", 12'hB00, 32'h5);
`else
        rd(12'h320, rdv, ilv);
        chk("mcountinhibit_absent_ill", {31'h0, ilv}, 32'h1);
        chk("mcountinhibit_absent_rd", rdv, 32'h0);
        repeat (5) @(negedge clk);
        chkrd("mcycle_runs", 12'hB00, 32'h5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
